// File: rtl/vga_timing_pkg.sv
// Shared VGA mode constants, the delay-line control bundle and the total-size helper
// used by the timing generator.
package vga_timing_pkg;

  localparam int unsigned VGA_COORD_W = 11;

  // 1440x900 @ 60 Hz
  localparam int unsigned M1440_H_ACTIVE = 1440;
  localparam int unsigned M1440_H_FP     = 80;
  localparam int unsigned M1440_H_SYNC   = 152;
  localparam int unsigned M1440_H_BP     = 232;
  localparam int unsigned M1440_V_ACTIVE = 900;
  localparam int unsigned M1440_V_FP     = 1;
  localparam int unsigned M1440_V_SYNC   = 3;
  localparam int unsigned M1440_V_BP     = 28;

  // 640x480 @ 60 Hz
  localparam int unsigned M640_H_ACTIVE  = 640;
  localparam int unsigned M640_H_FP      = 16;
  localparam int unsigned M640_H_SYNC    = 96;
  localparam int unsigned M640_H_BP      = 48;
  localparam int unsigned M640_V_ACTIVE  = 480;
  localparam int unsigned M640_V_FP      = 10;
  localparam int unsigned M640_V_SYNC    = 2;
  localparam int unsigned M640_V_BP      = 33;

  // 800x600 @ 60 Hz
  localparam int unsigned M800_H_ACTIVE  = 800;
  localparam int unsigned M800_H_FP      = 40;
  localparam int unsigned M800_H_SYNC    = 128;
  localparam int unsigned M800_H_BP      = 88;
  localparam int unsigned M800_V_ACTIVE  = 600;
  localparam int unsigned M800_V_FP      = 1;
  localparam int unsigned M800_V_SYNC    = 4;
  localparam int unsigned M800_V_BP      = 23;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } vga_ctl_t;

  function automatic int unsigned vga_total(input int unsigned sync, input int unsigned bp,
                                            input int unsigned active, input int unsigned fp);
    return sync + bp + active + fp;
  endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// pix_en-gated shift register with synchronous clear; DEPTH=0 is a plain wire.
module vga_pipe_delay #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk_i, clr_i, en_i};
    assign q_o = d_i;
  end else begin : g_sr
    logic [W-1:0] sr_q [DEPTH];

    always_ff @(posedge clk_i) begin
      if (clr_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else if (en_i) begin
        sr_q[0] <= d_i;
        for (int unsigned i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI timing generator: lookahead coordinates for draw logic, with
// sync/DE delayed DRAW_LAT ticks so they meet the returned colour at the output register.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = M1440_H_ACTIVE,
  parameter int unsigned H_FP     = M1440_H_FP,
  parameter int unsigned H_SYNC   = M1440_H_SYNC,
  parameter int unsigned H_BP     = M1440_H_BP,
  parameter int unsigned V_ACTIVE = M1440_V_ACTIVE,
  parameter int unsigned V_FP     = M1440_V_FP,
  parameter int unsigned V_SYNC   = M1440_V_SYNC,
  parameter int unsigned V_BP     = M1440_V_BP,
  parameter int unsigned HS_POL   = 1,
  parameter int unsigned VS_POL   = 1,
  parameter int unsigned DRAW_LAT = 1,
  parameter int unsigned CW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic [CW-1:0] draw_r,
  input  logic [CW-1:0] draw_g,
  input  logic [CW-1:0] draw_b,
  output logic [10:0]   curr_x,
  output logic [10:0]   curr_y,
  output logic          req_valid,
  output logic          line_start,
  output logic          frame_start,
  output logic [CW-1:0] pix_r,
  output logic [CW-1:0] pix_g,
  output logic [CW-1:0] pix_b,
  output logic          hsync,
  output logic          vsync,
  output logic          de
);

  localparam int unsigned H_TOT = vga_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int unsigned V_TOT = vga_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);

  if (H_TOT > 2048 || V_TOT > 2048) begin : g_err_tot
    $error("vga_timing_gen: H_TOT/V_TOT must not exceed 2048");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CW < 1) begin : g_err_min
    $error("vga_timing_gen: timing parameters and CW must be >= 1");
  end
  if (DRAW_LAT > 8) begin : g_err_lat
    $error("vga_timing_gen: DRAW_LAT must be in 0..8");
  end

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] HS_END = HW'(H_SYNC);
  localparam logic [HW-1:0] HA_BEG = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] HA_END = HW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] VS_END = VW'(V_SYNC);
  localparam logic [VW-1:0] VA_BEG = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] VA_END = VW'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic          HS_ACT = (HS_POL != 0);
  localparam logic          VS_ACT = (VS_POL != 0);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [HW-1:0] xoff;
  logic [VW-1:0] yoff;
  vga_ctl_t      ctl0, ctl_d;

  logic [CW-1:0] pix_r_q, pix_g_q, pix_b_q;
  logic          hs_q, vs_q, de_q;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
      end else begin
        hcnt_d = hcnt_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  always_comb begin
    ctl0     = '0;
    ctl0.hs  = (hcnt_q < HS_END);
    ctl0.vs  = (vcnt_q < VS_END);
    ctl0.act = (hcnt_q >= HA_BEG) && (hcnt_q < HA_END) &&
               (vcnt_q >= VA_BEG) && (vcnt_q < VA_END);
    xoff     = hcnt_q - HA_BEG;
    yoff     = vcnt_q - VA_BEG;
  end

  assign curr_x      = ctl0.act ? 11'(xoff) : '0;
  assign curr_y      = ctl0.act ? 11'(yoff) : '0;
  assign req_valid   = ctl0.act;
  assign line_start  = pix_en && ctl0.act && (hcnt_q == HA_BEG);
  assign frame_start = line_start && (vcnt_q == VA_BEG);

  vga_pipe_delay #(
    .W     ($bits(vga_ctl_t)),
    .DEPTH (DRAW_LAT)
  ) u_ctl_delay (
    .clk_i (clk),
    .clr_i (rst),
    .en_i  (pix_en),
    .d_i   (ctl0),
    .q_o   (ctl_d)
  );

  // Cleared delay stages read as hs=vs=0, so syncs leave reset in their inactive level.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_r_q <= '0;
      pix_g_q <= '0;
      pix_b_q <= '0;
      de_q    <= 1'b0;
      hs_q    <= ~HS_ACT;
      vs_q    <= ~VS_ACT;
    end else if (pix_en) begin
      pix_r_q <= ctl_d.act ? draw_r : '0;
      pix_g_q <= ctl_d.act ? draw_g : '0;
      pix_b_q <= ctl_d.act ? draw_b : '0;
      de_q    <= ctl_d.act;
      hs_q    <= ctl_d.hs ^~ HS_ACT;
      vs_q    <= ctl_d.vs ^~ VS_ACT;
    end
  end

  assign pix_r = pix_r_q;
  assign pix_g = pix_g_q;
  assign pix_b = pix_b_q;
  assign de    = de_q;
  assign hsync = hs_q;
  assign vsync = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a small 16x7 mode: two instances (positive and negative
// sync polarity) share stimulus and are compared each clock against a tick-count model.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 4, HS = 2, HB = 2;
  localparam int VA = 3, VF = 2, VS = 1, VB = 1;
  localparam int LAT = 2;
  localparam int CW  = 4;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_en = 1'b0;
  logic [CW-1:0] draw_r, draw_g, draw_b;

  logic [10:0]   curr_x, curr_y, curr_x_n, curr_y_n;
  logic          req_valid, line_start, frame_start;
  logic          req_valid_n, line_start_n, frame_start_n;
  logic [CW-1:0] pix_r, pix_g, pix_b, pix_r_n, pix_g_n, pix_b_n;
  logic          hsync, vsync, de, hsync_n, vsync_n, de_n;

  int n_chk = 0;
  int n_err = 0;
  int k     = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1), .VS_POL(1), .DRAW_LAT(LAT), .CW(CW)
  ) u_dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
    .curr_x(curr_x), .curr_y(curr_y), .req_valid(req_valid),
    .line_start(line_start), .frame_start(frame_start),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .hsync(hsync), .vsync(vsync), .de(de)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(0), .VS_POL(0), .DRAW_LAT(LAT), .CW(CW)
  ) u_dut_n (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
    .curr_x(curr_x_n), .curr_y(curr_y_n), .req_valid(req_valid_n),
    .line_start(line_start_n), .frame_start(frame_start_n),
    .pix_r(pix_r_n), .pix_g(pix_g_n), .pix_b(pix_b_n),
    .hsync(hsync_n), .vsync(vsync_n), .de(de_n)
  );

  // Draw logic: colour is a fixed function of the coordinate, returned LAT ticks later.
  logic [CW-1:0] dr_q [LAT];
  logic [CW-1:0] dg_q [LAT];
  logic [CW-1:0] db_q [LAT];

  always @(posedge clk) begin
    if (pix_en) begin
      dr_q[0] <= curr_x[3:0];
      dg_q[0] <= curr_y[3:0];
      db_q[0] <= curr_x[3:0] ^ curr_y[3:0];
      for (int i = 1; i < LAT; i++) begin
        dr_q[i] <= dr_q[i-1];
        dg_q[i] <= dg_q[i-1];
        db_q[i] <= db_q[i-1];
      end
    end
  end

  assign draw_r = dr_q[LAT-1];
  assign draw_g = dg_q[LAT-1];
  assign draw_b = db_q[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (tick %0d, t=%0t)", tag, got, exp, k, $time);
    end
  endtask

  function automatic bit in_act(input int p, input int l);
    return (p >= HS + HB) && (p < HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA);
  endfunction

  // Model: k ticks since reset fix the raster position; pins show position k-1-LAT.
  task automatic check_model();
    int p, l, ex, ey, j, pj, lj, xj, yj;
    bit a, aj, hsj, vsj;
    p  = k % HT;
    l  = (k / HT) % VT;
    a  = in_act(p, l);
    ex = a ? p - HS - HB : 0;
    ey = a ? l - VS - VB : 0;
    chk("req_valid",   req_valid, a);
    chk("curr_x",      curr_x, ex);
    chk("curr_y",      curr_y, ey);
    chk("line_start",  line_start, pix_en && a && ex == 0);
    chk("frame_start", frame_start, pix_en && a && ex == 0 && ey == 0);
    aj = 0; hsj = 0; vsj = 0; xj = 0; yj = 0;
    if (k >= LAT + 1) begin
      j   = k - 1 - LAT;
      pj  = j % HT;
      lj  = (j / HT) % VT;
      aj  = in_act(pj, lj);
      hsj = pj < HS;
      vsj = lj < VS;
      xj  = aj ? pj - HS - HB : 0;
      yj  = aj ? lj - VS - VB : 0;
    end
    chk("de",      de, aj);
    chk("hsync",   hsync, hsj);
    chk("vsync",   vsync, vsj);
    chk("pix_r",   pix_r, aj ? (xj & 15) : 0);
    chk("pix_g",   pix_g, aj ? (yj & 15) : 0);
    chk("pix_b",   pix_b, aj ? ((xj ^ yj) & 15) : 0);
    chk("de_n",    de_n, aj);
    chk("hsync_n", hsync_n, !hsj);
    chk("vsync_n", vsync_n, !vsj);
    chk("pix_r_n", pix_r_n, aj ? (xj & 15) : 0);
  endtask

  task automatic cycle(input logic r, input logic pe);
    rst    = r;
    pix_en = pe;
    @(posedge clk);
    if (r) k = 0;
    else if (pe) k++;
    @(negedge clk);
    check_model();
  endtask

  initial begin
    int n_de, n_hs, n_vs, n_fs, n_ls, max_x, max_y, n;
    bit found;

    @(negedge clk);
    cycle(1, 0);
    cycle(1, 1);
    cycle(1, 1);

    // Two frames at full rate; tally the second one.
    n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0; n_ls = 0; max_x = 0; max_y = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      cycle(0, 1);
      if (i >= HT * VT) begin
        n_de += int'(de);
        n_hs += int'(hsync);
        n_vs += int'(vsync);
        n_fs += int'(frame_start);
        n_ls += int'(line_start);
        if (req_valid && int'(curr_x) > max_x) max_x = int'(curr_x);
        if (req_valid && int'(curr_y) > max_y) max_y = int'(curr_y);
      end
    end
    chk("frame_de_clks",     n_de, 24);
    chk("frame_hsync_clks",  n_hs, 14);
    chk("frame_vsync_clks",  n_vs, 16);
    chk("frame_start_count", n_fs, 1);
    chk("line_start_count",  n_ls, 3);
    chk("max_curr_x",        max_x, HA - 1);
    chk("max_curr_y",        max_y, VA - 1);

    // 1-of-4 pixel tick over three frames.
    for (int i = 0; i < 3 * 4 * HT * VT; i++) cycle(0, (i % 4) == 3);

    // Reset in the middle of an active line, then time the first de.
    found = 0;
    for (int i = 0; i < 4 * HT * VT && !found; i++) begin
      cycle(0, 1);
      if (in_act(k % HT, (k / HT) % VT) && (k % HT) == HS + HB + 3) found = 1;
    end
    chk("mid_line_found", found, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1);
    n = 0;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      cycle(0, 1);
      n++;
      if (de) found = 1;
    end
    chk("first_de_seen", found, 1);
    chk("first_de_latency", n, (HS + HB) + (VS + VB) * HT + LAT + 1);

    // Random pixel-enable density with occasional resets of random length.
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(499, 0) == 0) begin
        int len;
        len = int'($urandom_range(4, 1));
        for (int r = 0; r < len; r++) cycle(1, 1'($urandom_range(1, 0)));
      end else begin
        cycle(0, $urandom_range(99, 0) < 70);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
